ssd1306_seq: RTL
================

// Module: ssd1306_seq
// PURPOSE
//  Command/data sequencer for the SSD1306 128x64 OLED over I2C. Sits directly upstream of
//  the I2C byte master and drives its byte handshake. After power-up it sends the init
//  command list, then streams frames from a pixel buffer on request.
// PARAMETERS
//  DEV_ADDR  7'h3C    7-bit slave address; first byte on the wire is {DEV_ADDR,1'b0} = 8'h78
//  PWR_DLY   50000    clk cycles of idle before init (1 ms @ 50 MHz)
//  INIT_LEN  25       entries in init ROM
// PORTS
//  clk         in   1   system clock, 50 MHz
//  rst_n       in   1   asynchronous active-low reset
//  frame_req   in   1   1-cycle pulse: send one full frame
//  init_done   out  1   high once init transaction ACKed completely
//  frame_busy  out  1   high from frame start to final STOP done
//  err         out  1   sticky: a NACK was reported; cleared only by reset
//  pix_addr    out  10  {page[2:0],col[6:0]} read address to pixel buffer
//  pix_data    in   8   buffer data, valid 1 clk after pix_addr (registered read)
//  tx_start    out  1   1-cycle pulse: downstream sends tx_byte
//  tx_byte     out  8   byte to send
//  tx_first    out  1   downstream issues START before this byte
//  tx_last     out  1   downstream issues STOP after this byte
//  tx_busy     in   1   downstream busy
//  tx_done     in   1   1-cycle pulse: byte (and STOP if tx_last) complete
//  tx_nack     in   1   valid with tx_done: slave NACKed the byte
// BEHAVIOUR
//  - Reset: all outputs 0, pix_addr=0, delay counter=0, pending flag=0, state PWR_WAIT.
//  - Handshake: tx_start pulses only when tx_busy=0; tx_byte/tx_first/tx_last held stable
//    from tx_start until tx_done. Exactly one tx_start per tx_done; next tx_start no earlier
//    than 1 clk after tx_done.
//  - States: PWR_WAIT -> INIT -> IDLE -> WIN -> PAGE -> IDLE; ERR -> PWR_WAIT.
//  - PWR_WAIT: count PWR_DLY cycles, then INIT.
//  - INIT: one transaction: 78(first), 00, then ROM AE D5 80 A8 3F D3 00 40 8D 14 20 00 A1 C8
//    DA 12 81 CF D9 F1 DB 40 A4 A6 AF(last) = 27 bytes. Final tx_done -> init_done=1, IDLE.
//  - IDLE: if pending or frame_req: clear pending, frame_busy=1, go WIN.
//  - WIN: one transaction 78(first) 00 21 00 7F 22 00 07(last) = 8 bytes.
//  - PAGE p=0..7: one transaction 78(first), 40, then 128 bytes col 0..127; col 127 tx_last.
//    For each data byte: drive pix_addr={p,col}, wait 1 clk, register pix_data into tx_byte,
//    then tx_start. After page 7 STOP: frame_busy=0, IDLE. pix_addr holds last value.
//  - frame_req while frame_busy or before init_done: set pending (1 deep; more requests
//    merge). Serviced on next IDLE entry; frame_req coincident with frame end -> pending.
//  - NACK (tx_nack=1 with tx_done) on any byte: err=1, init_done=0, frame_busy=0, pending
//    cleared, go ERR. Downstream owns STOP generation on NACK. ERR waits tx_busy=0, then
//    PWR_WAIT (counter restarts from 0) and full re-init.
//  - tx_done without outstanding tx_start: ignored.
//  - Async reset mid-transaction: immediate return to reset values; no STOP issued by this
//    block (downstream is reset by same rst_n).
//  - Counters: col 7 bit, page 3 bit, ROM index 5 bit; no wrap past terminal values.
// TESTING
//  1 Reset, hold rst_n=0 100 clk -> all outputs 0; release -> first tx_start at exactly
//    PWR_DLY+1..+2 clk, tx_byte=78, tx_first=1.
//  2 Slave model ACKs all, tx_done 20 clk after tx_start -> 27 bytes match init list,
//    tx_last only on AF, init_done rises 1 clk after last tx_done.
//  3 frame_req pulse, buffer data = addr[7:0] -> WIN 8 bytes, then 8 pages x 130 bytes;
//    page p data bytes = {p,col}[7:0]; tx_first on 78 only; frame_busy falls after 1048th
//    byte total of frame.
//  4 NACK on byte 3 of INIT -> err=1, no further tx_start until PWR_DLY elapses, re-init
//    completes, err stays 1.
//  5 Three frame_req pulses during a frame -> exactly one extra frame follows; frame_req
//    before init_done -> one frame right after init.
//  6 rst_n low mid-PAGE 4 -> outputs 0 within same clk edge; after release full init repeats.

Source files
------------

// File: rtl/ssd1306_seq.sv
// rtl/ssd1306_seq.sv - SSD1306 init/frame byte sequencer feeding an I2C byte master
module ssd1306_seq #(
   parameter logic [6:0] DEV_ADDR = 7'h3C,
   parameter int         PWR_DLY  = 50000,
   parameter int         INIT_LEN = 25
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       frame_req,
   output logic       init_done,
   output logic       frame_busy,
   output logic       err,
   output logic [9:0] pix_addr,
   input  logic [7:0] pix_data,
   output logic       tx_start,
   output logic [7:0] tx_byte,
   output logic       tx_first,
   output logic       tx_last,
   input  logic       tx_busy,
   input  logic       tx_done,
   input  logic       tx_nack
);
   localparam int         DW       = $clog2(PWR_DLY + 1);
   localparam logic [4:0] INIT_END = 5'(INIT_LEN + 1);
   localparam logic [7:0] ADDR_W   = {DEV_ADDR, 1'b0};

   typedef enum logic [2:0] {PWR_WAIT, INIT, IDLE, WIN, PAGE, ERR} state_t;

   state_t        state;
   logic [DW-1:0] dly_cnt;
   logic [4:0]    idx;
   logic [6:0]    col;
   logic [2:0]    page;
   logic [1:0]    fetch;
   logic          outstanding;
   logic          pending;
   logic          ack;
   logic          can_issue;

   function automatic logic [7:0] rom_byte(input logic [4:0] i);
      case (i)
         5'd0:  rom_byte = 8'hAE;
         5'd1:  rom_byte = 8'hD5;
         5'd2:  rom_byte = 8'h80;
         5'd3:  rom_byte = 8'hA8;
         5'd4:  rom_byte = 8'h3F;
         5'd5:  rom_byte = 8'hD3;
         5'd6:  rom_byte = 8'h00;
         5'd7:  rom_byte = 8'h40;
         5'd8:  rom_byte = 8'h8D;
         5'd9:  rom_byte = 8'h14;
         5'd10: rom_byte = 8'h20;
         5'd11: rom_byte = 8'h00;
         5'd12: rom_byte = 8'hA1;
         5'd13: rom_byte = 8'hC8;
         5'd14: rom_byte = 8'hDA;
         5'd15: rom_byte = 8'h12;
         5'd16: rom_byte = 8'h81;
         5'd17: rom_byte = 8'hCF;
         5'd18: rom_byte = 8'hD9;
         5'd19: rom_byte = 8'hF1;
         5'd20: rom_byte = 8'hDB;
         5'd21: rom_byte = 8'h40;
         5'd22: rom_byte = 8'hA4;
         5'd23: rom_byte = 8'hA6;
         5'd24: rom_byte = 8'hAF;
         default: rom_byte = 8'h00;
      endcase
   endfunction

   // Init transaction: address, control byte 00, then the ROM.
   function automatic logic [7:0] init_byte(input logic [4:0] i);
      if (i == 5'd0)      init_byte = ADDR_W;
      else if (i == 5'd1) init_byte = 8'h00;
      else                init_byte = rom_byte(i - 5'd2);
   endfunction

   // Column window 0..127, page window 0..7.
   function automatic logic [7:0] win_byte(input logic [2:0] i);
      case (i)
         3'd0:    win_byte = ADDR_W;
         3'd2:    win_byte = 8'h21;
         3'd4:    win_byte = 8'h7F;
         3'd5:    win_byte = 8'h22;
         3'd7:    win_byte = 8'h07;
         default: win_byte = 8'h00;
      endcase
   endfunction

   assign ack       = tx_done && outstanding;
   assign can_issue = !outstanding && !tx_busy;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= PWR_WAIT;
         dly_cnt     <= '0;
         idx         <= '0;
         col         <= '0;
         page        <= '0;
         fetch       <= '0;
         outstanding <= 1'b0;
         pending     <= 1'b0;
         init_done   <= 1'b0;
         frame_busy  <= 1'b0;
         err         <= 1'b0;
         pix_addr    <= '0;
         tx_start    <= 1'b0;
         tx_byte     <= '0;
         tx_first    <= 1'b0;
         tx_last     <= 1'b0;
      end else begin
         tx_start <= 1'b0;
         if (frame_req) pending <= 1'b1;

         if (ack && tx_nack) begin
            err         <= 1'b1;
            init_done   <= 1'b0;
            frame_busy  <= 1'b0;
            pending     <= 1'b0;
            outstanding <= 1'b0;
            fetch       <= '0;
            idx         <= '0;
            state       <= ERR;
         end else begin
            if (ack) outstanding <= 1'b0;
            case (state)
               PWR_WAIT: begin
                  if (dly_cnt == DW'(PWR_DLY - 1)) begin
                     dly_cnt <= '0;
                     idx     <= '0;
                     state   <= INIT;
                  end else begin
                     dly_cnt <= dly_cnt + 1'b1;
                  end
               end
               INIT: begin
                  if (ack) begin
                     if (tx_last) begin
                        init_done <= 1'b1;
                        state     <= IDLE;
                     end else begin
                        idx <= idx + 5'd1;
                     end
                  end else if (can_issue) begin
                     tx_byte     <= init_byte(idx);
                     tx_first    <= (idx == 5'd0);
                     tx_last     <= (idx == INIT_END);
                     tx_start    <= 1'b1;
                     outstanding <= 1'b1;
                  end
               end
               IDLE: begin
                  if (pending || frame_req) begin
                     pending    <= 1'b0;
                     frame_busy <= 1'b1;
                     idx        <= '0;
                     state      <= WIN;
                  end
               end
               WIN: begin
                  if (ack) begin
                     if (tx_last) begin
                        idx   <= '0;
                        col   <= '0;
                        page  <= '0;
                        state <= PAGE;
                     end else begin
                        idx <= idx + 5'd1;
                     end
                  end else if (can_issue) begin
                     tx_byte     <= win_byte(idx[2:0]);
                     tx_first    <= (idx == 5'd0);
                     tx_last     <= (idx == 5'd7);
                     tx_start    <= 1'b1;
                     outstanding <= 1'b1;
                  end
               end
               PAGE: begin
                  // idx 0/1 are the header bytes; idx 2 means streaming columns.
                  if (ack) begin
                     fetch <= '0;
                     if (idx != 5'd2) begin
                        idx <= idx + 5'd1;
                     end else if (col != 7'd127) begin
                        col <= col + 7'd1;
                     end else if (page != 3'd7) begin
                        page <= page + 3'd1;
                        col  <= '0;
                        idx  <= '0;
                     end else begin
                        frame_busy <= 1'b0;
                        state      <= IDLE;
                     end
                  end else if (!outstanding) begin
                     if (idx != 5'd2) begin
                        if (!tx_busy) begin
                           tx_byte     <= (idx == 5'd0) ? ADDR_W : 8'h40;
                           tx_first    <= (idx == 5'd0);
                           tx_last     <= 1'b0;
                           tx_start    <= 1'b1;
                           outstanding <= 1'b1;
                        end
                     end else begin
                        case (fetch)
                           2'd0: begin
                              pix_addr <= {page, col};
                              fetch    <= 2'd1;
                           end
                           2'd1: fetch <= 2'd2;
                           default: begin
                              if (!tx_busy) begin
                                 tx_byte     <= pix_data;
                                 tx_first    <= 1'b0;
                                 tx_last     <= (col == 7'd127);
                                 tx_start    <= 1'b1;
                                 outstanding <= 1'b1;
                              end
                           end
                        endcase
                     end
                  end
               end
               ERR: begin
                  if (!tx_busy) begin
                     dly_cnt <= '0;
                     state   <= PWR_WAIT;
                  end
               end
               default: state <= PWR_WAIT;
            endcase
         end
      end
   end
endmodule
